barrel_shift_scheduler: RTL and testbench

BARREL_SHIFT_SCHEDULER -- requirements
Module: barrel_shift_scheduler

---
 rtl/barrel_shift_scheduler_if.sv | 61 ++++++
 rtl/barrel_shift_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_barrel_shift_scheduler.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shift_scheduler_if.sv
// ---------------------------------------------------------------------------
// barrel_shift_scheduler_if
//
// Purpose: bundles the two requester channels, the response channel and the
// statistics counter of barrel_shift_scheduler into one interface.
//
// Signals:
//   reqN_valid      requester N (N=0,1) has an operation pending
//   reqN_ready      requester N's operation is accepted this cycle
//   reqN_select     0 = shift (zero fill), 1 = rotate
//   reqN_direction  0 = right, 1 = left
//   reqN_amount     total move distance, 0..7
//   reqN_din        4-bit operand
//   rsp_valid       result available
//   rsp_ready       consumer accepts the result
//   rsp_dout        4-bit result
//   rsp_id          index of the requester that owns the result
//   op_count        completed-operation count (0 unless stats are built in)
//
// Modports:
//   master  requesters plus response consumer (drives requests, rsp_ready)
//   slave   the scheduler itself
// ---------------------------------------------------------------------------
interface barrel_shift_scheduler_if;
    logic       req0_valid;
    logic       req0_ready;
    logic       req0_select;
    logic       req0_direction;
    logic [2:0] req0_amount;
    logic [3:0] req0_din;

    logic       req1_valid;
    logic       req1_ready;
    logic       req1_select;
    logic       req1_direction;
    logic [2:0] req1_amount;
    logic [3:0] req1_din;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_dout;
    logic       rsp_id;

    logic [7:0] op_count;

    modport master (
        output req0_valid, req0_select, req0_direction, req0_amount, req0_din,
        output req1_valid, req1_select, req1_direction, req1_amount, req1_din,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_dout, rsp_id, op_count
    );

    modport slave (
        input  req0_valid, req0_select, req0_direction, req0_amount, req0_din,
        input  req1_valid, req1_select, req1_direction, req1_amount, req1_din,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_dout, rsp_id, op_count
    );
endinterface

// File: rtl/barrel_shift_scheduler.sv
// ---------------------------------------------------------------------------
// barrel_shift_scheduler
//
// Purpose: shares one small 4-bit barrel shifter (0..3 positions per pass)
// between two requesters. Moves of 4..7 are built from up to three passes:
// amount[1:0] first, then two extra passes of 2. Grants are round-robin.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    barrel_shift_scheduler_if.slave (requests, response, op_count)
//
// Optional feature: define BSHIFT_SCHED_STATS_EN to build a saturating
// count of completed operations on op_count; otherwise op_count is tied to 0.
// ---------------------------------------------------------------------------

// Single-pass shifter: shift (zero fill) or rotate by 0..3 in either direction.
module barrel_shifter (
    input  logic [3:0] din,
    input  logic [1:0] shift_value,
    input  logic       select,
    input  logic       direction,
    output logic [3:0] dout
);
    logic [7:0] rot_left_wide;
    logic [7:0] rot_right_wide;

    // Rotations come from shifting a doubled copy of the operand.
    always_comb begin
        rot_left_wide  = {din, din} << shift_value;
        rot_right_wide = {din, din} >> shift_value;
        dout           = 4'd0;
        case ({select, direction})
            2'b00:   dout = din >> shift_value;
            2'b01:   dout = din << shift_value;
            2'b10:   dout = rot_right_wide[3:0];
            default: dout = rot_left_wide[7:4];
        endcase
    end
endmodule

module barrel_shift_scheduler (
    input  logic                     clk,
    input  logic                     rst_n,
    barrel_shift_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] pass_q, pass_d;
    logic       ptr_q, ptr_d;
    logic       sel_q, sel_d;
    logic       dir_q, dir_d;
    logic [2:0] amt_q, amt_d;
    logic [3:0] data_q, data_d;
    logic       id_q, id_d;

    logic       grant0;
    logic       grant1;
    logic [1:0] shift_value;
    logic [3:0] shifter_dout;
    logic       req0_ready;
    logic       req1_ready;
    logic       rsp_valid;
    logic [3:0] rsp_dout;
    logic       rsp_id;

    // The pointed requester wins a tie; a lone valid requester always wins.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
    assign grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr_q);

    // First pass moves by amount[1:0]; the extra passes move by 2 each.
    assign shift_value = (pass_q == 2'd0) ? amt_q[1:0] : 2'd2;

    barrel_shifter u_shifter (
        .din         (data_q),
        .shift_value (shift_value),
        .select      (sel_q),
        .direction   (dir_q),
        .dout        (shifter_dout)
    );

    // State and operation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= 2'd0;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
            dir_q   <= 1'b0;
            amt_q   <= 3'd0;
            data_q  <= 4'd0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            amt_q   <= amt_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    // Next-state and output logic. Ready is gated by rst_n so no grant is
    // shown while reset is held.
    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        dir_d      = dir_q;
        amt_d      = amt_q;
        data_d     = data_q;
        id_d       = id_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp_dout   = 4'd0;
        rsp_id     = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = rst_n && grant0;
                req1_ready = rst_n && grant1;
                if (grant0) begin
                    sel_d   = bus.req0_select;
                    dir_d   = bus.req0_direction;
                    amt_d   = bus.req0_amount;
                    data_d  = bus.req0_din;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    pass_d  = 2'd0;
                    state_d = SHIFT;
                end else if (grant1) begin
                    sel_d   = bus.req1_select;
                    dir_d   = bus.req1_direction;
                    amt_d   = bus.req1_amount;
                    data_d  = bus.req1_din;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    pass_d  = 2'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                data_d = shifter_dout;
                // Amounts below 4 finish after pass 0; others run passes 1 and 2.
                if ((pass_q == 2'd0 && !amt_q[2]) || pass_q == 2'd2) begin
                    pass_d  = 2'd0;
                    state_d = DONE;
                end else begin
                    pass_d = pass_q + 2'd1;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_dout  = data_q;
                rsp_id    = id_q;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_dout   = rsp_dout;
    assign bus.rsp_id     = rsp_id;

`ifdef BSHIFT_SCHED_STATS_EN
    logic [7:0] op_count_q, op_count_d;

    // Counts DONE-to-IDLE handshakes, sticking at 255.
    always_comb begin
        op_count_d = op_count_q;
        if (state_q == DONE && bus.rsp_ready && op_count_q != 8'hFF) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= 8'd0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign bus.op_count = op_count_q;
`else
    assign bus.op_count = 8'd0;
`endif
endmodule

// File: tb/tb_barrel_shift_scheduler.sv
// ---------------------------------------------------------------------------
// tb_barrel_shift_scheduler
//
// Directed bench for barrel_shift_scheduler. Inputs are driven and outputs
// sampled on the falling edge; the design acts on the rising edge.
// Expected op_count follows BSHIFT_SCHED_STATS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_barrel_shift_scheduler;
    logic clk;
    logic rst_n;

    int checkCount = 0;
    int errorCount = 0;
    int expOps     = 0;

    barrel_shift_scheduler_if bus ();

    barrel_shift_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Expected op_count for a given number of completed handshakes.
    function automatic int expectedCount(input int ops);
`ifdef BSHIFT_SCHED_STATS_EN
        return (ops > 255) ? 255 : ops;
`else
        return 0;
`endif
    endfunction

    // Presents one operation on requester id and raises its valid.
    task automatic applyStimulus(input int id, input logic sel, input logic dir,
                                 input logic [2:0] amt, input logic [3:0] din);
        if (id == 0) begin
            bus.req0_select    = sel;
            bus.req0_direction = dir;
            bus.req0_amount    = amt;
            bus.req0_din       = din;
            bus.req0_valid     = 1'b1;
        end else begin
            bus.req1_select    = sel;
            bus.req1_direction = dir;
            bus.req1_amount    = amt;
            bus.req1_din       = din;
            bus.req1_valid     = 1'b1;
        end
    endtask

    task automatic clearRequests();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Holds reset for two cycles with both requesters valid; everything must
    // read zero. Releases reset at a falling edge with requests cleared.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 3'd1, 4'b1000);
        applyStimulus(1, 1'b0, 1'b0, 3'd1, 4'b1000);
        #1;
        checkOutput("resetReady0", bus.req0_ready, 0);
        checkOutput("resetReady1", bus.req1_ready, 0);
        checkOutput("resetRspValid", bus.rsp_valid, 0);
        checkOutput("resetRspDout", bus.rsp_dout, 0);
        checkOutput("resetRspId", bus.rsp_id, 0);
        checkOutput("resetOpCount", bus.op_count, 0);
        @(negedge clk);
        @(negedge clk);
        clearRequests();
        rst_n  = 1'b1;
        expOps = 0;
    endtask

    // Runs one operation from a falling edge in IDLE. expEdges is the number
    // of rising edges after the accept edge before rsp_valid is seen; the
    // consumer stalls holdCycles cycles before taking the result.
    task automatic runOp(input int id, input logic sel, input logic dir,
                         input logic [2:0] amt, input logic [3:0] din,
                         input logic [3:0] expDout, input int expEdges,
                         input int holdCycles);
        int edges;
        bus.rsp_ready = (holdCycles == 0);
        applyStimulus(id, sel, dir, amt, din);
        #1;
        checkOutput("readyGranted", (id == 0) ? bus.req0_ready : bus.req1_ready, 1);
        checkOutput("readyOther", (id == 0) ? bus.req1_ready : bus.req0_ready, 0);
        @(negedge clk);
        clearRequests();
        checkOutput("busyNoReady", bus.req0_ready | bus.req1_ready, 0);
        edges = 0;
        while (!bus.rsp_valid && edges < 8) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("rspLatency", edges, expEdges);
        checkOutput("rspDout", bus.rsp_dout, expDout);
        checkOutput("rspId", bus.rsp_id, id);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("holdValid", bus.rsp_valid, 1);
            checkOutput("holdDout", bus.rsp_dout, expDout);
            checkOutput("holdId", bus.rsp_id, id);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        if (expOps < 255) expOps++;
        checkOutput("rspDropped", bus.rsp_valid, 0);
        checkOutput("opCount", bus.op_count, expectedCount(expOps));
    endtask

    initial begin
        int grants;
        int responses;
        int cycle;
        int lastGrant;
        int handshakes;

        rst_n = 1'b0;
        clearRequests();
        bus.req0_select = 1'b0; bus.req0_direction = 1'b0;
        bus.req0_amount = 3'd0; bus.req0_din = 4'd0;
        bus.req1_select = 1'b0; bus.req1_direction = 1'b0;
        bus.req1_amount = 3'd0; bus.req1_din = 4'd0;
        bus.rsp_ready = 1'b1;

        doReset();

        // Single-requester operations: id, select, direction, amount, din.
        runOp(0, 1'b0, 1'b0, 3'd1, 4'b1000, 4'b0100, 1, 0);
        runOp(1, 1'b1, 1'b1, 3'd5, 4'b1001, 4'b0011, 3, 0);
        runOp(0, 1'b0, 1'b1, 3'd0, 4'b1010, 4'b1010, 1, 0);
        runOp(1, 1'b1, 1'b0, 3'd3, 4'b0001, 4'b0010, 1, 0);
        runOp(0, 1'b0, 1'b0, 3'd4, 4'b1111, 4'b0000, 3, 0);
        runOp(1, 1'b1, 1'b0, 3'd6, 4'b0110, 4'b1001, 3, 0);
        runOp(0, 1'b0, 1'b1, 3'd2, 4'b0011, 4'b1100, 1, 0);
        runOp(1, 1'b0, 1'b1, 3'd7, 4'b1111, 4'b0000, 3, 0);

        // Stalled consumer: result must stay put until the handshake.
        runOp(0, 1'b0, 1'b1, 3'd6, 4'b1111, 4'b0000, 3, 5);
        runOp(1, 1'b1, 1'b1, 3'd1, 4'b0001, 4'b0010, 1, 3);

        // Both requesters valid every cycle: grants alternate 0,1,0,1 and
        // are spaced by a full accept/SHIFT/DONE round.
        doReset();
        bus.rsp_ready = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 3'd1, 4'b1000);
        applyStimulus(1, 1'b1, 1'b1, 3'd1, 4'b1001);
        grants    = 0;
        responses = 0;
        cycle     = 0;
        lastGrant = 0;
        while (responses < 4 && cycle < 80) begin
            if (grants == 4) clearRequests();
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                checkOutput("singleGrant", bus.req0_ready & bus.req1_ready, 0);
                checkOutput("grantOrder", bus.req1_ready, grants % 2);
                checkOutput("grantWhileBusy", bus.rsp_valid, 0);
                if (grants > 0) checkOutput("grantGap", cycle - lastGrant, 3);
                lastGrant = cycle;
                grants++;
            end
            if (bus.rsp_valid) begin
                checkOutput("rrRspId", bus.rsp_id, responses % 2);
                checkOutput("rrRspDout", bus.rsp_dout,
                            (responses % 2 == 0) ? 4'b0100 : 4'b0011);
                responses++;
            end
            @(negedge clk);
            cycle++;
        end
        clearRequests();
        checkOutput("rrGrants", grants, 4);
        checkOutput("rrResponses", responses, 4);
        checkOutput("rrOpCount", bus.op_count, expectedCount(4));

        // Reset during pass 1 of a 3-pass operation; pointer was left at 1.
        doReset();
        runOp(0, 1'b0, 1'b0, 3'd1, 4'b1000, 4'b0100, 1, 0);
        bus.rsp_ready = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 3'd5, 4'b1001);
        @(negedge clk);
        clearRequests();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 3'd1, 4'b1000);
        applyStimulus(1, 1'b1, 1'b1, 3'd1, 4'b1001);
        #1;
        checkOutput("abortRspValid", bus.rsp_valid, 0);
        checkOutput("abortRspDout", bus.rsp_dout, 0);
        checkOutput("abortRspId", bus.rsp_id, 0);
        checkOutput("abortReady", bus.req0_ready | bus.req1_ready, 0);
        checkOutput("abortOpCount", bus.op_count, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abortNoRsp", bus.rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("postResetGrant0", bus.req0_ready, 1);
        checkOutput("postResetGrant1", bus.req1_ready, 0);
        @(negedge clk);
        clearRequests();
        cycle = 0;
        while (!bus.rsp_valid && cycle < 8) begin
            @(negedge clk);
            cycle++;
        end
        checkOutput("postResetLatency", cycle, 1);
        checkOutput("postResetId", bus.rsp_id, 0);
        checkOutput("postResetDout", bus.rsp_dout, 4'b0100);
        @(negedge clk);

        // 300 back-to-back operations to exercise op_count saturation.
        doReset();
        bus.rsp_ready = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 3'd0, 4'b0101);
        handshakes = 0;
        cycle      = 0;
        while (handshakes < 300 && cycle < 3000) begin
            if (bus.rsp_valid) begin
                if (handshakes % 50 == 0 || handshakes == 254 || handshakes == 255)
                    checkOutput("statsCount", bus.op_count, expectedCount(handshakes));
                handshakes++;
                if (handshakes == 300) clearRequests();
            end
            @(negedge clk);
            cycle++;
        end
        checkOutput("statsOps", handshakes, 300);
        checkOutput("statsFinal", bus.op_count, expectedCount(300));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
